// File: rtl/mult_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_adder_pkg
//  Description : Shared constants, width helpers, saturation limits and FSM
//                state encoding for the multiply-add dot-product engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_adder_pkg;

    // Default geometry: operand lane width, lanes per vector, lanes per cycle
    localparam int C_BIT   = 8;
    localparam int C_LANES = 128;
    localparam int C_PAR   = 16;

    // Full signed product of two lanes
    function automatic int prod_width(input int bw);
        return 2 * bw;
    endfunction

    // Sum of one chunk of products; grows by log2 of the lanes summed
    function automatic int chunk_width(input int bw, input int par);
        return 2 * bw + $clog2(par);
    endfunction

    // Accumulator wide enough that the full dot product can never wrap
    function automatic int acc_width(input int bw, input int lanes);
        return 2 * bw + $clog2(lanes);
    endfunction

    // Saturated result width
    function automatic int res_width(input int bw);
        return 2 * bw - 1;
    endfunction

    // Saturation bounds of the result: [-2^(2*BIT-2), 2^(2*BIT-2)-1]
    function automatic longint sat_max(input int bw);
        return (longint'(1) << (2 * bw - 2)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int bw);
        return -(longint'(1) << (2 * bw - 2));
    endfunction

    localparam int     C_PROD_W  = prod_width(C_BIT);
    localparam int     C_ACC_W   = acc_width(C_BIT, C_LANES);
    localparam int     C_RES_W   = res_width(C_BIT);
    localparam longint C_SAT_MAX = sat_max(C_BIT);
    localparam longint C_SAT_MIN = sat_min(C_BIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mac_chunk.sv
`default_nettype none
// ============================================================================
//  Module      : mac_chunk
//  Description : Combinational multiply of PAR signed lane pairs followed by
//                an adder summing the PAR full-width products.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_chunk
    import mult_adder_pkg::*;
#(
    parameter int BIT = C_BIT,
    parameter int PAR = C_PAR
) (
    input  logic [PAR*BIT-1:0]                      i_opr_a,
    input  logic [PAR*BIT-1:0]                      i_opr_b,
    output logic signed [chunk_width(BIT, PAR)-1:0] o_sum
);

    localparam int C_LANE_PW = prod_width(BIT);
    localparam int C_SUM_W   = chunk_width(BIT, PAR);

    logic signed [C_LANE_PW-1:0] w_prod [PAR];
    logic signed [C_SUM_W-1:0]   w_sum;

    // One full-precision signed multiplier per lane
    for (genvar gi = 0; gi < PAR; gi++) begin : g_lane
        logic signed [BIT-1:0] w_a;
        logic signed [BIT-1:0] w_b;
        assign w_a        = i_opr_a[gi*BIT +: BIT];
        assign w_b        = i_opr_b[gi*BIT +: BIT];
        assign w_prod[gi] = C_LANE_PW'(w_a) * C_LANE_PW'(w_b);
    end

    // Sign-extend each product and sum the chunk
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < PAR; i++) begin
            w_sum = w_sum + C_SUM_W'(w_prod[i]);
        end
    end

    assign o_sum = w_sum;

endmodule
`default_nettype wire

// File: rtl/mult_adder_engine.sv
`default_nettype none
// ============================================================================
//  Module      : mult_adder_engine
//  Description : Signed dot-product engine. Captures two LANES-wide operand
//                vectors, accumulates PAR lane products per cycle, then emits
//                the sum saturated to 2*BIT-1 bits with an overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_adder_engine
    import mult_adder_pkg::*;
#(
    parameter int BIT   = C_BIT,
    parameter int LANES = C_LANES,
    parameter int PAR   = C_PAR
) (
    input  logic                       clk,
    input  logic                       iRst,
    input  logic                       ena,
    input  logic                       start,
    input  logic [LANES*BIT-1:0]       opr1,
    input  logic [LANES*BIT-1:0]       opr2,
    output logic [res_width(BIT)-1:0]  result,
    output logic                       overflow,
    output logic                       busy,
    output logic                       done
);

    localparam int C_RES_W      = res_width(BIT);
    localparam int C_ACC_W      = acc_width(BIT, LANES);
    localparam int C_SUM_W      = chunk_width(BIT, PAR);
    localparam int C_CHUNKS     = LANES / PAR;
    localparam int C_CNT_W      = (C_CHUNKS > 1) ? $clog2(C_CHUNKS) : 1;
    localparam int C_CHUNK_BITS = PAR * BIT;

    localparam logic [C_CNT_W-1:0]        C_LAST   = C_CNT_W'(C_CHUNKS - 1);
    localparam logic signed [C_ACC_W-1:0] C_SAT_HI = C_ACC_W'(sat_max(BIT));
    localparam logic signed [C_ACC_W-1:0] C_SAT_LO = C_ACC_W'(sat_min(BIT));

    state_t                       r_state;
    state_t                       w_state_next;
    logic [C_CNT_W-1:0]           r_cnt;
    logic signed [C_ACC_W-1:0]    r_acc;
    logic signed [C_ACC_W-1:0]    w_acc_next;
    logic [LANES*BIT-1:0]         r_opr1;
    logic [LANES*BIT-1:0]         r_opr2;
    logic [C_CHUNK_BITS-1:0]      w_chunk_a;
    logic [C_CHUNK_BITS-1:0]      w_chunk_b;
    logic signed [C_SUM_W-1:0]    w_chunk_sum;
    logic [C_RES_W-1:0]           w_sat;
    logic                         w_ovf;
    logic [C_RES_W-1:0]           r_result;
    logic                         r_overflow;
    logic                         w_accept;

    assign w_accept = (r_state == S_IDLE) && start;

    // Chunk k of the captured operands feeds the multiplier array
    assign w_chunk_a = r_opr1[int'(r_cnt)*C_CHUNK_BITS +: C_CHUNK_BITS];
    assign w_chunk_b = r_opr2[int'(r_cnt)*C_CHUNK_BITS +: C_CHUNK_BITS];

    mac_chunk #(
        .BIT (BIT),
        .PAR (PAR)
    ) u_mac_chunk (
        .i_opr_a (w_chunk_a),
        .i_opr_b (w_chunk_b),
        .o_sum   (w_chunk_sum)
    );

    // State register; reset wins over the clock enable
    always_ff @(posedge clk) begin
        if (iRst) begin
            r_state <= S_IDLE;
        end else if (ena) begin
            r_state <= w_state_next;
        end
    end

    // Next-state: start only honoured in IDLE, OUT always returns to IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)          w_state_next = S_ACC;
            S_ACC:   if (r_cnt == C_LAST) w_state_next = S_OUT;
            S_OUT:                        w_state_next = S_IDLE;
            default:                      w_state_next = S_IDLE;
        endcase
    end

    // Next accumulator value and its clamp into the result range
    always_comb begin
        w_acc_next = r_acc + C_ACC_W'(w_chunk_sum);
        w_sat      = w_acc_next[C_RES_W-1:0];
        w_ovf      = 1'b0;
        if (w_acc_next > C_SAT_HI) begin
            w_sat = C_RES_W'(C_SAT_HI);
            w_ovf = 1'b1;
        end else if (w_acc_next < C_SAT_LO) begin
            w_sat = C_RES_W'(C_SAT_LO);
            w_ovf = 1'b1;
        end
    end

    // Operand capture at acceptance; operands are don't-care until then
    always_ff @(posedge clk) begin
        if (!iRst && ena && w_accept) begin
            r_opr1 <= opr1;
            r_opr2 <= opr2;
        end
    end

    // Counter, accumulator and result registers; result is loaded on the
    // final chunk so it is already valid in the OUT (done) cycle
    always_ff @(posedge clk) begin
        if (iRst) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else if (ena) begin
            if (w_accept) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else if (r_state == S_ACC) begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= w_acc_next;
                if (r_cnt == C_LAST) begin
                    r_result   <= w_sat;
                    r_overflow <= w_ovf;
                end
            end
        end
    end

    assign result   = r_result;
    assign overflow = r_overflow;
    assign busy     = (r_state != S_IDLE);
    // done is masked by ena so a frozen OUT cycle never shows a pulse
    assign done     = (r_state == S_OUT) && ena && !iRst;

endmodule
`default_nettype wire

// File: doc/mult_adder_engine.md
MULT_ADDER_ENGINE -- requirements
Module: mult_adder_engine

Interface
REQ-001 Parameter BIT, default 8, width of one signed two's-complement operand lane.
REQ-002 Parameter LANES, default 128, number of lanes per operand vector.
REQ-003 Parameter PAR, default 16, lanes multiplied per cycle; LANES divisible by PAR.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 iRst  input  1  reset, synchronous and active-high.
REQ-006 ena  input  1  clock enable; low freezes all state and outputs.
REQ-007 start  input  1  request pulse; sampled only in IDLE.
REQ-008 opr1  input  LANES*BIT  operand vector A; lane i at bits [i*BIT+BIT-1 -: BIT].
REQ-009 opr2  input  LANES*BIT  operand vector B; same lane layout.
REQ-010 result  output  2*BIT-1  saturated signed dot product sum(A[i]*B[i]).
REQ-011 overflow  output  1  high when result was saturated.
REQ-012 busy  output  1  high from the cycle after accepted start until done.
REQ-013 done  output  1  one-cycle pulse marking result/overflow valid.

Function
REQ-014 The engine SHALL have states IDLE, ACC, OUT.
REQ-015 In IDLE with ena=1 and start=1, it SHALL register opr1/opr2 and clear the chunk counter and accumulator, then enter ACC.
REQ-016 Operands SHALL be captured at acceptance; later input changes SHALL have no effect on the current operation.
REQ-017 Each ACC cycle SHALL add the sum of PAR lane products of chunk k (lanes k*PAR..k*PAR+PAR-1) to the accumulator and increment k.
REQ-018 After chunk LANES/PAR-1, the engine SHALL enter OUT.
REQ-019 Products SHALL be full 2*BIT-bit signed, and the accumulator SHALL be 2*BIT+log2(LANES) bits wide, so it never wraps internally.
REQ-020 In OUT, result SHALL be the accumulator clamped to [-2^(2*BIT-2), 2^(2*BIT-2)-1].
REQ-021 In OUT, overflow SHALL be 1 if clamping changed the value and 0 otherwise.
REQ-022 In OUT, done SHALL pulse for one cycle and the engine SHALL return to IDLE.
REQ-023 Latency SHALL be LANES/PAR+1 enabled cycles from the accept edge to the done cycle; this is 9 at default parameters.
REQ-024 result and overflow SHALL hold their values until the next OUT.
REQ-025 busy SHALL be high in ACC and OUT and low in IDLE.
REQ-026 start asserted while busy SHALL be ignored and not queued.
REQ-027 start asserted in the done cycle SHALL be ignored, because the engine is not yet in IDLE.
REQ-028 With ena=0, state, counter, accumulator and outputs SHALL hold, and done SHALL stay low; operation resumes when ena returns to 1.
REQ-029 A single accepted start SHALL produce exactly one done pulse.

Reset
REQ-030 With iRst=1 at a clock edge, the engine SHALL enter IDLE with result=0, overflow=0, busy=0, done=0, and counter and accumulator cleared.
REQ-031 iRst SHALL take priority over ena and start.
REQ-032 Reset mid-operation SHALL abort without a done pulse.

Structure
REQ-033 BIT, LANES, PAR, the derived widths (product, accumulator, result) and the saturation limits SHALL reside in the shared package mult_adder_pkg.
REQ-034 The PAR-lane multiply and adder tree SHALL be one combinational sub-module, mac_chunk.
REQ-035 The state machine, counter, accumulator and saturation SHALL reside in mult_adder_engine.

Verification
REQ-036 All lanes 0 with start -> done at cycle 9, result=0, overflow=0.
REQ-037 Lane0 A=3, B=-5, other lanes 0 -> result=-15, overflow=0.
REQ-038 All lanes A=127, B=127 (sum 2064512) -> result=16383, overflow=1; all lanes A=-128, B=1 -> result=-16384, overflow=0 (exact bound).
REQ-039 Start at cycle 0, start again at cycle 3, inputs changed at cycle 2 -> one done at cycle 9 with the first operands' result.
REQ-040 ena low for cycles 4-6 mid-ACC -> done at cycle 12 with the correct result.
REQ-041 iRst at cycle 5 mid-ACC -> busy=0 and no done; a new start afterwards completes normally.
